// File: rtl/phoenix_pwm_pkg.sv
// Shared definitions for the LED controller's pwm_cycle/pwm_duty interface.
// The default counter width matches the LED controller's counter.
package phoenix_pwm_pkg;

    localparam int PWM_COUNTER_BITS_DEFAULT = 32;

    typedef logic [PWM_COUNTER_BITS_DEFAULT-1:0] pwm_count_t;

endpackage

// File: rtl/phoenix_pwm_generator.sv
// PWM output stage: shadows the period/duty request at period boundaries and
// drives a registered, glitch-free waveform plus period/update pulses.
module phoenix_pwm_generator
    import phoenix_pwm_pkg::*;
#(
    parameter int PWM_COUNTER_BITS = PWM_COUNTER_BITS_DEFAULT,
    parameter bit OUTPUT_INVERT    = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [PWM_COUNTER_BITS-1:0] pwm_cycle,
    input  logic [PWM_COUNTER_BITS-1:0] pwm_duty,
    output logic                        pwm_out,
    output logic                        period_start,
    output logic                        update_ack
);

    localparam logic [PWM_COUNTER_BITS-1:0] ONE = PWM_COUNTER_BITS'(1);

    logic [PWM_COUNTER_BITS-1:0] cnt;
    logic [PWM_COUNTER_BITS-1:0] cyc_q;
    logic [PWM_COUNTER_BITS-1:0] duty_q;

    logic running;
    logic load;
    logic active;
    logic shadow_change;

    // Idle (cyc_q==0) and disabled both force a reload every cycle, so the
    // first enabled cycle always begins a fresh period at cnt==0.
    always_comb begin
        running       = enable && (cyc_q != '0);
        load          = (cyc_q == '0) || (cnt == cyc_q - ONE) || !enable;
        active        = running && (cnt < duty_q);
        shadow_change = (pwm_cycle != cyc_q) || (pwm_duty != duty_q);
    end

    // Shadow registers and period counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            cyc_q  <= '0;
            duty_q <= '0;
        end else if (load) begin
            cnt    <= '0;
            cyc_q  <= pwm_cycle;
            duty_q <= pwm_duty;
        end else begin
            cnt    <= cnt + ONE;
        end
    end

    // Output and pulse registers, one cycle behind the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_out      <= OUTPUT_INVERT;
            period_start <= 1'b0;
            update_ack   <= 1'b0;
        end else begin
            pwm_out      <= active ^ OUTPUT_INVERT;
            period_start <= running && (cnt == '0);
            update_ack   <= load && shadow_change;
        end
    end

endmodule
